// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared constants and types for the floating-point multiplier stages.
//   - exponent bias default, all-ones exponent code
//   - field widths of the mantissa-multiply stage result
//   - iteration geometry (bits consumed per cycle, iteration count)
//   - FSM state encoding
// Build option: FPMUL_RADIX4_EN selects two multiplier bits per iteration
// (12 iterations) instead of one (24 iterations).
package fpmul_pkg;

  localparam int          BIAS_DEFAULT = 127;
  localparam logic [7:0]  EXP_MAX      = 8'hFF;

  localparam int MANT_W = 24;  // mantissa with hidden one
  localparam int PROD_W = 25;  // product bits P[47:23]
  localparam int EXP_W  = 9;   // exponent result width
  localparam int ESUM_W = 10;  // signed exponent sum, wide enough for -127..383
  localparam int ACC_W  = 48;  // full 24x24 product

`ifdef FPMUL_RADIX4_EN
  localparam int RAD_SHIFT = 2;
  localparam int ITER      = 12;
`else
  localparam int RAD_SHIFT = 1;
  localparam int ITER      = 24;
`endif

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fpmul_mant_iter_if.sv
// fpmul_mant_iter_if: operand/result handshake bundle of the mantissa-multiply stage.
//   in_valid/in_ready   operand handshake, a/b binary32 operands
//   out_valid/out_ready result handshake
//   product_o           P[47:23], exponent_o biased exponent sum
//   sign_o, exception_o sign and Inf/NaN/overflow/underflow flag
// Modports: master (operand source / result sink), slave (the stage).
interface fpmul_mant_iter_if;
  import fpmul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product_o;
  logic [EXP_W-1:0]  exponent_o;
  logic              sign_o;
  logic              exception_o;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product_o, exponent_o, sign_o, exception_o
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product_o, exponent_o, sign_o, exception_o
  );

endinterface

// File: rtl/fpmul_shift_add_step.sv
// fpmul_shift_add_step: one combinational shift-add iteration.
//   i_acc        running 48-bit partial product
//   i_mcand      multiplicand already aligned to the current bit position
//   i_mcand3     3x multiplicand, aligned likewise (radix-4 build only)
//   i_mult_bits  multiplier bits consumed this iteration
//   o_acc_next   accumulator after this iteration
// Build option: FPMUL_RADIX4_EN consumes two multiplier bits per iteration.
module fpmul_shift_add_step
  import fpmul_pkg::*;
(
  input  logic [ACC_W-1:0]     i_acc,
  input  logic [ACC_W-1:0]     i_mcand,
`ifdef FPMUL_RADIX4_EN
  input  logic [ACC_W-1:0]     i_mcand3,
`endif
  input  logic [RAD_SHIFT-1:0] i_mult_bits,
  output logic [ACC_W-1:0]     o_acc_next
);

`ifdef FPMUL_RADIX4_EN
  logic [ACC_W-1:0] w_addend;

  always_comb begin
    w_addend = '0;
    case (i_mult_bits)
      2'b01:   w_addend = i_mcand;
      2'b10:   w_addend = i_mcand << 1;
      2'b11:   w_addend = i_mcand3;
      default: w_addend = '0;
    endcase
  end

  assign o_acc_next = i_acc + w_addend;
`else
  assign o_acc_next = i_acc + (i_mult_bits[0] ? i_mcand : '0);
`endif

endmodule

// File: rtl/fpmul_mant_iter.sv
// fpmul_mant_iter: iterative mantissa-multiply stage of the binary32 multiplier.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous active-high; forces IDLE and clears all state
//   bus    fpmul_mant_iter_if.slave (operand and result handshakes, result fields)
// Parameter: BIAS exponent bias (default 127).
// Build option: FPMUL_RADIX4_EN -> 12 iterations of two bits, otherwise 24 of one.
// Zero/denormal, Inf/NaN and exponent out-of-range operands bypass the iteration
// and produce a result one cycle after acceptance.
module fpmul_mant_iter
  import fpmul_pkg::*;
#(
  parameter int BIAS = BIAS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  fpmul_mant_iter_if.slave bus
);

  state_t r_state;
  state_t w_state_next;
  logic   w_in_ready;
  logic   w_out_valid;

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_mcand;   // multiplicand, shifted left each iteration
  logic [MANT_W-1:0] r_mult;    // multiplier, shifted right each iteration
`ifdef FPMUL_RADIX4_EN
  logic [ACC_W-1:0]  r_mcand3;
`endif
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign;
  logic [EXP_W-1:0]  r_esum;

  logic [PROD_W-1:0] r_product;
  logic [EXP_W-1:0]  r_exponent;
  logic              r_sign_o;
  logic              r_exc;

  // Operand decode, evaluated on the acceptance cycle
  logic [7:0]               w_ea;
  logic [7:0]               w_eb;
  logic signed [ESUM_W-1:0] w_esum;
  logic                     w_exc_cond;
  logic                     w_zero_cond;
  logic                     w_fast;
  logic [ACC_W-1:0]         w_acc_next;
  logic                     w_last;

  assign w_ea   = bus.a[30:23];
  assign w_eb   = bus.b[30:23];
  assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - $signed(ESUM_W'(BIAS));

  // The exception flag takes priority over the zero shortcut when both apply.
  assign w_exc_cond  = (w_ea == EXP_MAX) || (w_eb == EXP_MAX) ||
                       (w_esum >= 10'sd255) || (w_esum <= 10'sd0);
  assign w_zero_cond = (w_ea == 8'd0) || (w_eb == 8'd0);
  assign w_fast      = w_exc_cond || w_zero_cond;
  assign w_last      = (r_cnt == CNT_W'(ITER - 1));

  fpmul_shift_add_step u_step (
    .i_acc       (r_acc),
    .i_mcand     (r_mcand),
`ifdef FPMUL_RADIX4_EN
    .i_mcand3    (r_mcand3),
`endif
    .i_mult_bits (r_mult[RAD_SHIFT-1:0]),
    .o_acc_next  (w_acc_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = w_fast ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and result registers; results persist after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mult     <= '0;
`ifdef FPMUL_RADIX4_EN
      r_mcand3   <= '0;
`endif
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_esum     <= '0;
      r_product  <= '0;
      r_exponent <= '0;
      r_sign_o   <= 1'b0;
      r_exc      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sign  <= bus.a[31] ^ bus.b[31];
            r_esum  <= w_esum[EXP_W-1:0];
            r_mcand <= ACC_W'({1'b1, bus.a[22:0]});
            r_mult  <= {1'b1, bus.b[22:0]};
`ifdef FPMUL_RADIX4_EN
            r_mcand3 <= ACC_W'({1'b1, bus.a[22:0]}) * ACC_W'(3);
`endif
            if (w_fast) begin
              r_product  <= '0;
              r_exponent <= '0;
              r_sign_o   <= bus.a[31] ^ bus.b[31];
              r_exc      <= w_exc_cond;
            end
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << RAD_SHIFT;
          r_mult  <= r_mult >> RAD_SHIFT;
`ifdef FPMUL_RADIX4_EN
          r_mcand3 <= r_mcand3 << RAD_SHIFT;
`endif
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_product  <= w_acc_next[ACC_W-1:ACC_W-PROD_W];
            r_exponent <= r_esum;
            r_sign_o   <= r_sign;
            r_exc      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.product_o   = r_product;
  assign bus.exponent_o  = r_exponent;
  assign bus.sign_o      = r_sign_o;
  assign bus.exception_o = r_exc;

endmodule

// File: tb/tb_fpmul_mant_iter.sv
// tb_fpmul_mant_iter: scoreboard bench for fpmul_mant_iter. Expected results
// come from a behavioural model (native multiply) and are queued on drive,
// popped when out_valid rises.
module tb_fpmul_mant_iter;

  localparam int BIAS = 127;
`ifdef FPMUL_RADIX4_EN
  localparam int NORM_LAT = 13;
`else
  localparam int NORM_LAT = 25;
`endif

  typedef struct {
    logic [24:0] product;
    logic [8:0]  exponent;
    logic        sign;
    logic        exc;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  fpmul_mant_iter_if bus ();

  fpmul_mant_iter #(.BIAS(BIAS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t        e;
    int          ea;
    int          eb;
    int          es;
    logic [47:0] p;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    es = ea + eb - BIAS;
    e.name = name;
    e.sign = a[31] ^ b[31];
    e.product = '0;
    e.exponent = '0;
    e.exc = 1'b0;
    e.lat = 1;
    if (ea == 255 || eb == 255 || es >= 255 || es <= 0) begin
      e.exc = 1'b1;
    end else if (ea == 0 || eb == 0) begin
      e.exc = 1'b0;
    end else begin
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e.product = p[47:23];
      e.exponent = 9'(es);
      e.lat = NORM_LAT;
    end
    return e;
  endfunction

  // One operation; hold = cycles out_ready stays low once the result appears.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string name);
    exp_t e;
    int   lat;
    sb.push_back(model(a, b, name));
    @(negedge clk);
    check({name, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({name, ".latency"},  64'(lat),             64'(e.lat));
    check({name, ".product"},  64'(bus.product_o),   64'(e.product));
    check({name, ".exponent"}, 64'(bus.exponent_o),  64'(e.exponent));
    check({name, ".sign"},     64'(bus.sign_o),      64'(e.sign));
    check({name, ".exc"},      64'(bus.exception_o), 64'(e.exc));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, ".hold_valid"},   64'(bus.out_valid), 64'd1);
      check({name, ".hold_ready"},   64'(bus.in_ready),  64'd0);
      check({name, ".hold_product"}, 64'(bus.product_o), 64'(e.product));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({name, ".post_in_ready"},  64'(bus.in_ready),  64'd1);
    check({name, ".post_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, ".post_product"},   64'(bus.product_o), 64'(e.product));
    $display("op %-10s a=%08h b=%08h prod=%07h exp=%03h s=%0d exc=%0d lat=%0d",
             name, a, b, bus.product_o, bus.exponent_o, bus.sign_o, bus.exception_o, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.in_ready",  64'(bus.in_ready),    64'd1);
    check("rst.out_valid", 64'(bus.out_valid),   64'd0);
    check("rst.product",   64'(bus.product_o),   64'd0);
    check("rst.exponent",  64'(bus.exponent_o),  64'd0);
    check("rst.sign",      64'(bus.sign_o),      64'd0);
    check("rst.exc",       64'(bus.exception_o), 64'd0);
    $display("reset state checked");
    reset = 1'b0;

    do_op(32'h3FC00000, 32'h40000000, 0, "1.5x2");
    do_op(32'hBFC00000, 32'h3FC00000, 0, "-1.5x1.5");
    do_op(32'h00000000, 32'h40400000, 0, "zero");
    do_op(32'h7F800000, 32'h3F800000, 0, "inf");
    do_op(32'h7F000000, 32'h7F000000, 0, "ovf");
    do_op(32'h00800000, 32'h00800000, 0, "unf");
    do_op(32'h3FFFFFFF, 32'h3FFFFFFF, 0, "maxmant");
    do_op(32'h3FC00000, 32'h40000000, 5, "hold5");

    for (int i = 0; i < 6; i++) begin
      ra = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
      do_op(ra, rb, 0, $sformatf("rand%0d", i));
    end

    // Abort a multiply in RUN with reset
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 32'h40490FDB;
    bus.b        = 32'h402DF854;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.in_ready",  64'(bus.in_ready),  64'd1);
    check("abort.out_valid", 64'(bus.out_valid), 64'd0);
    check("abort.product",   64'(bus.product_o), 64'd0);
    $display("reset during RUN checked");

    do_op(32'hBFC00000, 32'h3FC00000, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpmul_mant_iter.md
# fpmul_mant_iter

Iterative mantissa-multiply stage of the single-precision floating-point multiplier. It accepts two IEEE-754 binary32 operands over a valid/ready handshake and computes the sign, biased exponent sum and 24×24 mantissa product using a multi-cycle shift-add datapath. It sits directly upstream of the normalize stage and delivers the 25-bit unnormalized product, the 9-bit exponent, the sign and the exception flag in the format that stage consumes.

## Interface
- `BIAS`, default 127: exponent bias subtracted from the sum of exponents.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the `clk` rising edge.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: stage can accept operands (high in IDLE only).
- `a`, `b` in 32 each: binary32 operands.
- `out_valid` out 1: result valid; held until consumed.
- `out_ready` in 1: downstream accepts the result.
- `product_o` out 25: product bits P[47:23].
- `exponent_o` out 9: exponent sum minus `BIAS`.
- `sign_o` out 1: a[31] ^ b[31].
- `exception_o` out 1: Inf/NaN operand, exponent overflow or exponent underflow.

## Operation
- Reset values:
  - all outputs 0, except `in_ready`, which is 1 (IDLE).
  - accumulator, counter and operand registers 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `in_valid && in_ready` when the operands take the normal path.
  - IDLE → DONE on acceptance when the operands take the fast path.
  - RUN → DONE when `cnt == ITER-1`.
  - DONE → IDLE on `out_ready` (`out_valid` is high in DONE).
- On accept:
  - latch ma={1,a[22:0]}, mb={1,b[22:0]} and the sign.
  - compute esum = a[30:23] + b[30:23] − BIAS in a 10-bit signed value.
- Fast path (no iteration):
  - Either exponent == 0 (zero/denormal, treated as zero): product 0, exponent 0, exception 0, sign = xor.
  - Either exponent == 255, esum ≥ 255, or esum ≤ 0: product 0, exponent 0, exception 1.
  - If the zero and exception conditions are both present, exception wins.
- RUN, radix-2:
  - Each cycle, if the current LSB of the multiplier is 1, add ma shifted to the current position into a 48-bit accumulator.
  - ITER = 24.
- Product P ∈ [2^46, 2^48). Output `product_o`=P[47:23], so bits [24:23] are 01 or 1x. P[22:0] is discarded (no sticky).
- `exponent_o` = esum[8:0] on the normal path.
- Outputs are registered and stable for the whole DONE state. They are not cleared on handshake and hold until the next result is loaded.
- `in_ready` is low throughout RUN and DONE, so there is no overlap between operations.
- Reset in any state forces IDLE on the same edge, aborting the operation. No partial result is emitted.

## Timing
- Accept edge = cycle 0.
- Normal path, radix-2: RUN occupies cycles 1–24, and `out_valid` is high from cycle 25.
- Fast path: `out_valid` is high from cycle 1.
- With `out_ready` held high, the result is consumed on its first valid cycle. `in_ready` is high the following cycle.
- Throughput: one result per ITER+2 cycles, or per 2 cycles on the fast path.

## Configuration
- `FPMUL_RADIX4_EN` defined:
  - two multiplier bits per cycle (adds 0, 1×, 2× or 3× ma; 3× precomputed on accept).
  - ITER = 12, `out_valid` from cycle 13.
- Undefined: radix-2, ITER = 24.
- Results are bit-identical in both modes.

## Structure
- Shared package `fpmul_pkg`:
  - BIAS default, EXP_MAX = 8'hFF.
  - field widths (MANT_W=24, PROD_W=25, EXP_W=9).
  - state enum {IDLE, RUN, DONE}.
- Sub-module `fpmul_shift_add_step`: combinational single iteration (accumulator, multiplicand, multiplier bits → next accumulator), radix selected by the macro.

## Test plan
- a=0x3FC00000, b=0x40000000 → `product_o`=0x0C00000, `exponent_o`=0x080, sign 0, exc 0, `out_valid` at cycle 25 (13 with radix-4).
- a=0xBFC00000, b=0x3FC00000 → `product_o`=0x1200000, `exponent_o`=0x07F, sign 1, exc 0.
- a=0x00000000, b=0x40400000 → fast path at cycle 1: product 0, exp 0, exc 0.
- a=0x7F800000 or a=b=0x7F000000 (esum=381) or a=b=0x00800000 (esum=−125) → exc 1, product 0, exp 0, cycle 1.
- `out_ready` held low 5 cycles in DONE → outputs stable, `in_ready`=0. Release → `in_ready`=1 the next cycle.
- `reset` asserted at cycle 10 of RUN → next cycle IDLE, `out_valid`=0, `in_ready`=1. A following operation gives the correct result.
